// File: rtl/chip_burst_ctrl.sv
// rtl/chip_burst_ctrl.sv - burst controller driving one bank of a multi-bank chip
// Latches a request in IDLE, plays BL column beats to one bank, returns a completion.
module chip_burst_ctrl #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int CHWIDTH      = 5,
  parameter int RDLAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [BGWIDTH-1:0]           req_bg,
  input  logic [BAWIDTH-1:0]           req_ba,
  input  logic [CHWIDTH-1:0]           req_row,
  input  logic [COLWIDTH-1:0]          req_col,
  input  logic [BL*DEVICE_WIDTH-1:0]   req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [BL*DEVICE_WIDTH-1:0]   rsp_rdata,
  output logic                         rd_o_wr [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [DEVICE_WIDTH-1:0]      dqin    [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  input  logic [DEVICE_WIDTH-1:0]      dqout   [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [CHWIDTH-1:0]           row     [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0],
  output logic [COLWIDTH-1:0]          column  [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0]
);

  // counter is shared between burst beats and the drain wait, so it must hold RDLAT-1 too
  localparam int CW = ($clog2(BL) > 2) ? $clog2(BL) : 2;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             beat;
  logic                      ready_q;
  logic                      accept;
  logic                      write_q;
  logic [BGWIDTH-1:0]        bg_q;
  logic [BAWIDTH-1:0]        ba_q;
  logic [CHWIDTH-1:0]        row_q;
  logic [COLWIDTH-1:0]       col_q;
  logic [BL*DEVICE_WIDTH-1:0] wdata_q;
  logic                      tap_v;
  logic [CW-1:0]             tap_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_q;
        if (req_valid && ready_q) state_n = req_write ? WRITE : READ;
      end
      WRITE:   if (beat == CW'(BL - 1)) state_n = RESP;
      READ:    if (beat == CW'(BL - 1)) state_n = DRAIN;
      DRAIN:   if (beat == CW'(RDLAT - 1)) state_n = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign rsp_write = write_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      beat      <= '0;
      write_q   <= 1'b0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        beat      <= '0;
        write_q   <= req_write;
        bg_q      <= req_bg;
        ba_q      <= req_ba;
        row_q     <= req_row;
        col_q     <= req_col;
        wdata_q   <= req_wdata;
        rsp_rdata <= '0;
      end else if (state == WRITE || state == READ || state == DRAIN) begin
        beat <= (state_n != state) ? '0 : beat + CW'(1);
      end
      if (tap_v) rsp_rdata[int'(tap_i)*DEVICE_WIDTH +: DEVICE_WIDTH] <= dqout[bg_q][ba_q];
      // registered valid leaves one settle cycle in RESP before the completion is offered
      rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
    end
  end

  // beat index travels alongside the chip's read latency to the capture point
  generate
    if (RDLAT == 1) begin : g_nodly
      assign tap_v = (state == READ);
      assign tap_i = beat;
    end else begin : g_dly
      logic          dv [RDLAT-1];
      logic [CW-1:0] di [RDLAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RDLAT - 1; i++) begin
            dv[i] <= 1'b0;
            di[i] <= '0;
          end
        end else begin
          dv[0] <= (state == READ);
          di[0] <= beat;
          for (int i = 1; i < RDLAT - 1; i++) begin
            dv[i] <= dv[i-1];
            di[i] <= di[i-1];
          end
        end
      end
      assign tap_v = dv[RDLAT-2];
      assign tap_i = di[RDLAT-2];
    end
  endgenerate

  always_comb begin
    for (int g = 0; g < 2**BGWIDTH; g++) begin
      for (int b = 0; b < 2**BAWIDTH; b++) begin
        rd_o_wr[g][b] = 1'b0;
        dqin[g][b]    = '0;
        row[g][b]     = '0;
        column[g][b]  = '0;
      end
    end
    if (state == WRITE || state == READ) begin
      rd_o_wr[bg_q][ba_q] = (state == WRITE);
      row[bg_q][ba_q]     = row_q;
      column[bg_q][ba_q]  = col_q + COLWIDTH'(beat);
      dqin[bg_q][ba_q]    = (state == WRITE) ? wdata_q[int'(beat)*DEVICE_WIDTH +: DEVICE_WIDTH] : '0;
    end
  end

endmodule

// File: tb/tb_chip_burst_ctrl.sv
// tb/tb_chip_burst_ctrl.sv - self-checking bench for chip_burst_ctrl
// Behavioural multi-bank chip, vector table of bursts, response scoreboard.
module tb_chip_burst_ctrl;
  localparam int BGW = 2, BAW = 2, CW = 10, DW = 4, BL = 8, CHW = 5, RDLAT = 1;
  localparam int NG = 4, NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write;
  logic [BGW-1:0] req_bg;
  logic [BAW-1:0] req_ba;
  logic [CHW-1:0] req_row;
  logic [CW-1:0]  req_col;
  logic [BL*DW-1:0] req_wdata, rsp_rdata;
  logic          rd_o_wr [NG-1:0][NB-1:0];
  logic [DW-1:0] dqin    [NG-1:0][NB-1:0];
  logic [DW-1:0] dqout   [NG-1:0][NB-1:0];
  logic [CHW-1:0] row    [NG-1:0][NB-1:0];
  logic [CW-1:0] column  [NG-1:0][NB-1:0];

  always #5 clk = ~clk;

  chip_burst_ctrl #(.BGWIDTH(BGW), .BAWIDTH(BAW), .COLWIDTH(CW), .DEVICE_WIDTH(DW),
                    .BL(BL), .CHWIDTH(CHW), .RDLAT(RDLAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rd_o_wr(rd_o_wr), .dqin(dqin), .dqout(dqout), .row(row), .column(column));

  // chip model: write on the edge, zero-latency combinational read
  logic [DW-1:0] mem [NG][NB][32][1024];
  always @(posedge clk)
    for (int g = 0; g < NG; g++)
      for (int b = 0; b < NB; b++)
        if (rd_o_wr[g][b]) mem[g][b][row[g][b]][column[g][b]] <= dqin[g][b];
  always_comb
    for (int g = 0; g < NG; g++)
      for (int b = 0; b < NB; b++)
        dqout[g][b] = mem[g][b][row[g][b]][column[g][b]];

  typedef struct {
    logic        wr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [4:0]  rw;
    logic [9:0]  col;
    logic [31:0] data;
    int          hold;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          lat;
  } rsp_t;

  rsp_t sb [$];
  vec_t vecs [9];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic others_busy(input int sg, input int sbk);
    logic a;
    a = 1'b0;
    for (int g = 0; g < NG; g++)
      for (int b = 0; b < NB; b++)
        if (!(g == sg && b == sbk))
          a |= rd_o_wr[g][b] | (|row[g][b]) | (|column[g][b]) | (|dqin[g][b]);
    return a;
  endfunction

  task automatic drive_req(input vec_t v);
    req_write = v.wr;
    req_bg    = v.bg;
    req_ba    = v.ba;
    req_row   = v.rw;
    req_col   = v.col;
    req_wdata = v.wr ? v.data : $urandom;
    req_valid = 1'b1;
  endtask

  task automatic check_beat(input vec_t v, input int k);
    logic [9:0]  ec;
    logic [31:0] wd;
    ec = v.col + 10'(k);
    wd = v.data;
    check($sformatf("beat%0d_sel", k),
          {rd_o_wr[v.bg][v.ba], row[v.bg][v.ba], column[v.bg][v.ba], dqin[v.bg][v.ba]},
          {v.wr, v.rw, ec, v.wr ? wd[4*k +: 4] : 4'h0});
    check($sformatf("beat%0d_others_idle", k), others_busy(v.bg, v.ba), 0);
  endtask

  task automatic run_vec(input vec_t v);
    rsp_t exp;
    int   edges, waited;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    drive_req(v);
    sb.push_back('{v.wr, v.wr ? 32'h0 : v.data, v.wr ? BL + 1 : BL + RDLAT + 1});
    @(posedge clk);
    edges = 0;
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      check_beat(v, k);
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    check("post_burst_idle", others_busy(-1, -1), 0);
    waited = 0;
    while (!rsp_valid && waited < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: actual no rsp_valid required rsp_valid within 50 cycles");
    end
    exp = sb.pop_front();
    check("rsp_latency", edges, exp.lat);
    check("rsp_write", rsp_write, exp.wr);
    check("rsp_rdata", rsp_rdata, exp.rdata);
    check("req_ready_resp", req_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      req_write = $urandom;
      req_bg = $urandom;
      req_ba = $urandom;
      req_row = $urandom;
      req_col = $urandom;
      req_wdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_stable", {req_ready, rsp_valid, rsp_write, rsp_rdata}, {1'b0, 1'b1, exp.wr, exp.rdata});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    vec_t rv;
    logic seen;
    req_valid = 0; req_write = 0; req_bg = 0; req_ba = 0; req_row = 0;
    req_col = 0; req_wdata = 0; rsp_ready = 0;
    vecs[0] = '{1'b1, 2'd1, 2'd1, 5'd1,  10'd0,    32'h19C50F3A, 0};
    vecs[1] = '{1'b0, 2'd1, 2'd1, 5'd1,  10'd0,    32'h19C50F3A, 0};
    vecs[2] = '{1'b1, 2'd2, 2'd3, 5'd7,  10'd1020, 32'h87654321, 0};
    vecs[3] = '{1'b0, 2'd2, 2'd3, 5'd7,  10'd1020, 32'h87654321, 5};
    vecs[4] = '{1'b1, 2'd0, 2'd0, 5'd31, 10'd1023, 32'hDEADBEEF, 2};
    vecs[5] = '{1'b0, 2'd0, 2'd0, 5'd31, 10'd1023, 32'hDEADBEEF, 0};
    vecs[6] = '{1'b0, 2'd1, 2'd1, 5'd1,  10'd0,    32'h19C50F3A, 0};
    vecs[7] = '{1'b1, 2'd3, 2'd2, 5'd0,  10'd5,    32'hA5C3E17B, 1};
    vecs[8] = '{1'b0, 2'd3, 2'd2, 5'd0,  10'd5,    32'hA5C3E17B, 0};

    repeat (2) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, rsp_write, rsp_rdata}, 0);
    check("reset_banks_idle", others_busy(-1, -1), 0);
    rst_n = 1'b1;
    #1 check("ready_low_before_edge", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset lands in the middle of a read that has already captured three beats
    rv = vecs[1];
    @(negedge clk);
    drive_req(rv);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check_beat(rv, 3);
    rst_n = 1'b0;
    #1;
    check("abort_banks_idle", others_busy(-1, -1), 0);
    check("abort_outputs", {req_ready, rsp_valid, rsp_write, rsp_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_after_release", req_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("abort_no_rsp", seen, 0);
    run_vec(vecs[6]);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual time limit reached required test completion");
    $fatal(1);
  end
endmodule

// File: doc/chip_burst_ctrl.md
CHIP_BURST_CTRL -- requirements
Module: chip_burst_ctrl

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, meaning bank-group address width (BANKGROUPS = 2**BGWIDTH).
REQ-002 SHALL have parameter BAWIDTH, default 2, meaning bank address width (BANKSPERGROUP = 2**BAWIDTH).
REQ-003 SHALL have parameter COLWIDTH, default 10, meaning column address width (COLS = 2**COLWIDTH).
REQ-004 SHALL have parameter DEVICE_WIDTH, default 4, meaning data bits per beat.
REQ-005 SHALL have parameter BL, default 8, meaning beats per burst.
REQ-006 SHALL have parameter CHWIDTH, default 5, meaning row address width.
REQ-007 SHALL have parameter RDLAT, default 1, meaning chip read latency in cycles (1..4).
REQ-008 Ports: clk  input  1  single clock, all logic on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 req_valid  input  1  request offered; req_ready  output  1  controller accepts.
REQ-011 req_write  input  1  1 = write burst, 0 = read burst.
REQ-012 req_bg  input  BGWIDTH, req_ba  input  BAWIDTH, req_row  input  CHWIDTH, req_col  input  COLWIDTH  target bank and start address.
REQ-013 req_wdata  input  BL*DEVICE_WIDTH  write beats; beat k = bits [k*DEVICE_WIDTH +: DEVICE_WIDTH].
REQ-014 rsp_valid  output  1, rsp_ready  input  1, rsp_write  output  1, rsp_rdata  output  BL*DEVICE_WIDTH  completion and read data, same beat packing.
REQ-015 Chip side, unpacked [BANKGROUPS-1:0][BANKSPERGROUP-1:0]: rd_o_wr  output  1, dqin  output  DEVICE_WIDTH, dqout  input  DEVICE_WIDTH, row  output  CHWIDTH, column  output  COLWIDTH.

Function
REQ-016 SHALL use FSM states IDLE, WRITE, READ, DRAIN, RESP.
REQ-017 IDLE: req_ready=1 and no other state asserts it; a request is accepted on an edge with req_valid & req_ready, latching all req_* fields.
REQ-018 Accepted write -> WRITE for exactly BL cycles; beat k drives rd_o_wr=1, row=req_row, column=(req_col+k) mod COLS, dqin=beat k to the selected bank.
REQ-019 Accepted read -> READ for exactly BL cycles; beat k drives rd_o_wr=0, row=req_row, column=(req_col+k) mod COLS, dqin=0.
REQ-020 Read capture: dqout of the selected bank SHALL be sampled into rsp_rdata beat k RDLAT edges after the edge that presented column beat k.
REQ-021 READ -> DRAIN for RDLAT cycles (chip outputs all zero), then -> RESP once all BL beats are captured.
REQ-022 WRITE -> RESP directly after beat BL-1; rsp_rdata SHALL be all zero for writes.
REQ-023 RESP: rsp_valid=1, rsp_write=latched req_write, rsp_rdata stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-024 Non-selected banks, and all banks outside WRITE/READ, SHALL see rd_o_wr=0, row=0, column=0, dqin=0.
REQ-025 Column arithmetic SHALL wrap modulo COLS within COLWIDTH bits; row never increments.
REQ-026 req_valid outside IDLE SHALL be ignored and the request not latched.
REQ-027 Minimum turnaround: request accepted in IDLE on the edge after RESP completes; no back-to-back overlap of bursts.
REQ-028 Write latency: rsp_valid rises BL+1 edges after acceptance; read latency BL+RDLAT+1 edges.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, req_ready=0 while asserted, rsp_valid=0, rsp_write=0, rsp_rdata=0, all chip outputs 0.
REQ-030 Reset mid-burst SHALL abort the burst, discard partial read data, and issue no response; req_ready=1 on the first edge after rst_n rises.

Verification
REQ-031 Write bg=1 ba=1 row=1 col=0 beats 0..7 = {A,3,F,0,5,C,9,1} -> bank[1][1] sees rd_o_wr=1 columns 0..7 with those dqin; rsp_valid at edge 9, rsp_write=1.
REQ-032 Read same address after write -> bank[1][1] columns 0..7 with rd_o_wr=0; rsp_rdata beats equal {A,3,F,0,5,C,9,1}; rsp_valid at edge 10 (RDLAT=1).
REQ-033 Write/read at col=1020 -> columns 1020,1021,1022,1023,0,1,2,3; readback matches.
REQ-034 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored; completes on rsp_ready=1.
REQ-035 Assert rst_n=0 at READ beat 3 -> all outputs zero immediately, no rsp_valid after release, req_ready=1 one edge after release.
REQ-036 During every burst, all 15 non-selected banks hold rd_o_wr=0, row=0, column=0, dqin=0.
